// File: rtl/qc_ldpc_pkg.sv
// Shared types, constants and prototype shift table for the QC-LDPC accumulator engine.
package qc_ldpc_pkg;

    localparam int PKG_NUM_Z         = 3;
    localparam int PKG_NUM_PAR_BLKS  = 4;
    localparam int PKG_NUM_INFO_BLKS = 20;
    localparam int PKG_MAX_Z         = 81;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Width of a circulant shift value for a given largest lifting size.
    function automatic int shift_width(input int max_z);
        return (max_z > 1) ? $clog2(max_z) : 1;
    endfunction

    localparam int SHIFT_W = shift_width(PKG_MAX_Z);
    typedef logic [SHIFT_W-1:0] shift_t;

    // All-ones shift marks an absent circulant (zero block in the base matrix).
    localparam shift_t NULL_SHIFT = '1;
    localparam int     NS         = (1 << SHIFT_W) - 1;

    // Base-matrix shifts indexed [z_sel][row][col]; every non-null entry is below its Z.
    localparam int SHIFT_TABLE [PKG_NUM_Z][PKG_NUM_PAR_BLKS][PKG_NUM_INFO_BLKS] = '{
        // Z = 27
        '{
            '{ 0,  5, 12, NS,  3, 26,  8, NS, 14,  1, 20,  9, NS, 17,  6, 22, 11,  2, NS, 25},
            '{ 7, NS, 19,  4, 10, NS, 23, 15,  0, 13, NS, 24, 18,  5, NS,  9, 16, 21,  3, NS},
            '{NS, 14,  2, 20, NS, 11,  6, 25, NS,  8, 17,  0,  4, NS, 22, 13, NS, 19, 26, 10},
            '{ 1, 26, NS,  9, 16,  2, NS, 12, 21, NS,  5, 18, 23,  7,  0, NS, 24,  6, 15, 13}
        },
        // Z = 54
        '{
            '{ 3, 40, NS, 17, 52,  8, 29, NS, 45, 11,  0, 33, 21, NS, 50,  6, 38, 14, NS, 27},
            '{NS, 19, 44,  2, NS, 31,  9, 53, 24, NS, 15, 47,  1, 36, NS, 22,  5, 41, 12, NS},
            '{28, NS,  7, 49, 35, NS, 16,  4, NS, 43, 26, 10, NS, 51, 18, 39, NS, 30,  2, 46},
            '{10, 53, 25, NS,  6, 42, NS, 20, 37, 13, NS,  0, 48,  8, 32, NS, 27, 15, 44,  1}
        },
        // Z = 81
        '{
            '{ 0, 64, 33, NS, 79, 12, 51, NS, 26, 70,  5, NS, 44, 18, 80, NS, 37,  9, 60, 22},
            '{41, NS, 15, 72,  3, NS, 57, 28, NS, 66, 11, 49, NS, 35,  2, 76, NS, 20, 53,  8},
            '{NS, 80, 47,  6, NS, 24, 68, 39, 13, NS, 58, 31, 74, NS, 17, 45,  1, NS, 62, 29},
            '{55, 19, NS, 40, 71, 10, NS, 36, 63, NS, 25, 78,  7, 50, NS, 14, 67, 33, NS,  4}
        }
    };

endpackage

// File: rtl/qc_ldpc_shift_rom.sv
// Combinational lookup of one row's circulant shift for the current lifting size and column.
module qc_ldpc_shift_rom
    import qc_ldpc_pkg::*;
#(
    parameter int NUM_Z         = 3,
    parameter int NUM_PAR_BLKS  = 4,
    parameter int NUM_INFO_BLKS = 20,
    parameter int MAX_Z         = 81,
    localparam int ZI_W = (NUM_Z > 1) ? $clog2(NUM_Z) : 1,
    localparam int ROW_W = (NUM_PAR_BLKS > 1) ? $clog2(NUM_PAR_BLKS) : 1,
    localparam int COL_W = (NUM_INFO_BLKS > 1) ? $clog2(NUM_INFO_BLKS) : 1,
    localparam int SW = shift_width(MAX_Z)
) (
    input  logic [ZI_W-1:0]  z_sel,
    input  logic [ROW_W-1:0] row,
    input  logic [COL_W-1:0] col,
    output logic [SW-1:0]    shift
);

    // Out-of-table coordinates read as an absent circulant.
    always_comb begin
        shift = SW'(NULL_SHIFT);
        if (int'(z_sel) < NUM_Z && int'(z_sel) < PKG_NUM_Z &&
            int'(row) < NUM_PAR_BLKS && int'(row) < PKG_NUM_PAR_BLKS &&
            int'(col) < NUM_INFO_BLKS && int'(col) < PKG_NUM_INFO_BLKS) begin
            shift = SW'(SHIFT_TABLE[z_sel][row][col]);
        end
    end

endmodule

// File: rtl/qc_ldpc_accum_engine.sv
// QC-LDPC parity accumulator: XORs rotated info blocks into one accumulator per
// parity row, then streams the rows out with a valid/ready handshake.
module qc_ldpc_accum_engine
    import qc_ldpc_pkg::*;
#(
    parameter int NUM_Z         = 3,
    parameter int MAX_Z         = 81,
    parameter int NUM_INFO_BLKS = 20,
    parameter int NUM_PAR_BLKS  = 4,
    parameter int Z_VALUES [NUM_Z] = '{27, 54, 81}
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_Z-1:0] req_z,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAX_Z-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAX_Z-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             cfg_err
);

    localparam int ZI_W  = (NUM_Z > 1) ? $clog2(NUM_Z) : 1;
    localparam int ROW_W = (NUM_PAR_BLKS > 1) ? $clog2(NUM_PAR_BLKS) : 1;
    localparam int COL_W = (NUM_INFO_BLKS > 1) ? $clog2(NUM_INFO_BLKS) : 1;
    localparam int SW    = shift_width(MAX_Z);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_INFO_BLKS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_PAR_BLKS - 1);

    state_t           state_reg;
    logic [ZI_W-1:0]  z_idx_reg;
    logic [COL_W-1:0] col_reg;
    logic [ROW_W-1:0] row_reg;
    logic [MAX_Z-1:0] accum_reg [NUM_PAR_BLKS];
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             out_last_reg;
    logic             busy_reg;
    logic             cfg_err_reg;

    logic             req_onehot;
    logic [ZI_W-1:0]  req_idx;
    int               z_cur;
    logic [SW-1:0]    shift_w [NUM_PAR_BLKS];
    logic [MAX_Z-1:0] rot_w   [NUM_PAR_BLKS];

    // Right cyclic rotation inside the low z bits; everything above z reads as zero.
    function automatic logic [MAX_Z-1:0] rot(input logic [MAX_Z-1:0] x, input int z, input int s);
        logic [MAX_Z-1:0] r;
        int idx;
        r = '0;
        for (int k = 0; k < MAX_Z; k++) begin
            if (k < z) begin
                idx = k + s;
                if (idx >= z) idx = idx - z;
                if (idx < MAX_Z) r[k] = x[idx];
            end
        end
        return r;
    endfunction

    // Decode the lifting-size request into a table index and flag malformed requests.
    always_comb begin
        req_onehot = $onehot(req_z);
        req_idx    = '0;
        for (int i = 0; i < NUM_Z; i++) begin
            if (req_z[i]) req_idx = ZI_W'(i);
        end
    end

    // Active lifting size for the latched selector.
    always_comb begin
        z_cur = Z_VALUES[0];
        if (int'(z_idx_reg) < NUM_Z) z_cur = Z_VALUES[z_idx_reg];
    end

    // One shift lookup and rotator per parity row so all rows update in the same beat.
    generate
        for (genvar gi = 0; gi < NUM_PAR_BLKS; gi++) begin : g_row
            qc_ldpc_shift_rom #(
                .NUM_Z         (NUM_Z),
                .NUM_PAR_BLKS  (NUM_PAR_BLKS),
                .NUM_INFO_BLKS (NUM_INFO_BLKS),
                .MAX_Z         (MAX_Z)
            ) u_rom (
                .z_sel (z_idx_reg),
                .row   (ROW_W'(gi)),
                .col   (col_reg),
                .shift (shift_w[gi])
            );
            assign rot_w[gi] = (shift_w[gi] == SW'(NULL_SHIFT)) ? '0
                             : rot(data_in, z_cur, int'(shift_w[gi]));
        end
    endgenerate

    // Control FSM, accumulators and registered handshake flags.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            z_idx_reg     <= '0;
            col_reg       <= '0;
            row_reg       <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            cfg_err_reg   <= 1'b0;
            for (int r = 0; r < NUM_PAR_BLKS; r++) accum_reg[r] <= '0;
        end else begin
            cfg_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (req_onehot) begin
                            z_idx_reg    <= req_idx;
                            col_reg      <= '0;
                            row_reg      <= '0;
                            for (int r = 0; r < NUM_PAR_BLKS; r++) accum_reg[r] <= '0;
                            state_reg    <= ST_ACCUM;
                            in_ready_reg <= 1'b1;
                            busy_reg     <= 1'b1;
                        end else begin
                            cfg_err_reg  <= 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    // in_ready is held high throughout this state, so in_valid alone is a beat.
                    if (in_valid) begin
                        for (int r = 0; r < NUM_PAR_BLKS; r++) accum_reg[r] <= accum_reg[r] ^ rot_w[r];
                        if (col_reg == LAST_COL) begin
                            state_reg     <= ST_DRAIN;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                            out_last_reg  <= (NUM_PAR_BLKS == 1);
                            row_reg       <= '0;
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (row_reg == LAST_ROW) begin
                            state_reg     <= ST_IDLE;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            busy_reg      <= 1'b0;
                        end else begin
                            row_reg      <= row_reg + 1'b1;
                            out_last_reg <= (int'(row_reg) + 1 == NUM_PAR_BLKS - 1);
                        end
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    in_ready_reg  <= 1'b0;
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;
    assign cfg_err   = cfg_err_reg;
    assign out_data  = out_valid_reg ? accum_reg[row_reg] : '0;

endmodule

// File: doc/qc_ldpc_accum_engine.md
QC_LDPC_ACCUM_ENGINE -- requirements
Module: qc_ldpc_accum_engine

Interface
REQ-001 SHALL have parameter NUM_Z, default 3, number of supported lifting sizes.
REQ-002 SHALL have parameter MAX_Z, default 81, largest lifting size and datapath width.
REQ-003 SHALL have parameter NUM_INFO_BLKS, default 20, info columns per codeword.
REQ-004 SHALL have parameter NUM_PAR_BLKS, default 4, parity rows (accumulators).
REQ-005 SHALL have parameter Z_VALUES[NUM_Z], default {27, 54, 81}, lifting size per req_z bit.
REQ-006 SHALL have port CLK  input  1  single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port start  input  1  request a new codeword; sampled only in IDLE.
REQ-009 SHALL have port req_z  input  NUM_Z  one-hot lifting size select; sampled with start.
REQ-010 SHALL have port in_valid  input  1  info block beat valid.
REQ-011 SHALL have port in_ready  output  1  engine accepts an info block.
REQ-012 SHALL have port data_in  input  MAX_Z  info block; only bits [Z-1:0] are used.
REQ-013 SHALL have port out_valid  output  1  accumulator result valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts a result.
REQ-015 SHALL have port out_data  output  MAX_Z  accumulated row vector; bits [MAX_Z-1:Z] are zero.
REQ-016 SHALL have port out_last  output  1  marks row NUM_PAR_BLKS-1.
REQ-017 SHALL have port busy  output  1  high in any state except IDLE.
REQ-018 SHALL have port cfg_err  output  1  one-cycle pulse when start arrives with a non-one-hot req_z.

Function
REQ-019 SHALL implement FSM IDLE -> ACCUM -> DRAIN -> IDLE.
REQ-020 IDLE: start with one-hot req_z SHALL latch the z selector, clear all accumulators and column counter, and enter ACCUM next cycle.
REQ-021 IDLE: start with zero or multi-hot req_z SHALL pulse cfg_err for one cycle and remain in IDLE.
REQ-022 start outside IDLE SHALL be ignored.
REQ-023 ACCUM: in_ready SHALL be 1, and each in_valid&&in_ready beat SHALL process column col in one cycle.
REQ-024 Per beat, for every row r in parallel, accum[r] SHALL update to accum[r] XOR rot(data_in[Z-1:0], s[z][r][col]).
REQ-025 rot(x,s) SHALL be a right cyclic rotation within Z bits: result bit k = x[(k+s) mod Z].
REQ-026 A shift entry of all ones (null, no circulant) SHALL leave accum[r] unchanged.
REQ-027 Shift width SHALL be $clog2(MAX_Z), and non-null entries SHALL be less than Z.
REQ-028 The beat with col = NUM_INFO_BLKS-1 SHALL move the FSM to DRAIN on the next cycle; col SHALL NOT wrap within a codeword.
REQ-029 DRAIN: in_ready SHALL be 0 and out_valid SHALL be 1, with out_data = accum[row] starting at row 0.
REQ-030 DRAIN: row SHALL advance on each out_valid&&out_ready.
REQ-031 DRAIN: the handshake on row NUM_PAR_BLKS-1, with out_last=1, SHALL return the FSM to IDLE.
REQ-032 DRAIN: while out_ready=0, out_data, out_last and out_valid SHALL hold stable.
REQ-033 Latency: out_valid SHALL rise on the cycle after the final input beat.
REQ-034 Latency: a minimum codeword SHALL take 1 + NUM_INFO_BLKS + NUM_PAR_BLKS cycles from start to IDLE.
REQ-035 in_valid while in_ready=0 SHALL be ignored, and no data SHALL be captured.

Reset
REQ-036 rst_n low SHALL asynchronously force IDLE.
REQ-037 rst_n low SHALL clear all accumulators, col, row and the z selector.
REQ-038 During reset, outputs SHALL be: in_ready=0, out_valid=0, out_last=0, busy=0, cfg_err=0, out_data=0.
REQ-039 Reset mid-ACCUM or mid-DRAIN SHALL abandon the codeword with no partial output after deassertion.

Structure
REQ-040 Package qc_ldpc_pkg SHALL hold the state enum, the null-shift constant, the shift width function, and the prototype shift table [NUM_Z][NUM_PAR_BLKS][NUM_INFO_BLKS].
REQ-041 Sub-module qc_ldpc_shift_rom SHALL be combinational.
REQ-042 qc_ldpc_shift_rom SHALL take inputs (z_sel, row, col) and return the shift for one row; it SHALL be instantiated once per row.
REQ-043 Rotation SHALL be a local automatic function masked to Z bits.

Verification
REQ-044 Z=27, a single beat with data_in bit0=1 at col 0 and zeros elsewhere: row r SHALL give bit (27-s[0][r][0]) mod 27 set, or zero if the entry is null.
REQ-045 Z=81, all-zero data for 20 beats: 4 outputs SHALL be 0; out_last SHALL be on the 4th output; busy SHALL fall after it.
REQ-046 start with req_z=3'b011: cfg_err SHALL pulse one cycle, busy SHALL stay 0, and in_ready SHALL stay 0.
REQ-047 Random in_valid gaps and out_ready held low for 5 cycles: outputs SHALL match the package-table reference model and stay stable while stalled.
REQ-048 rst_n low after beat 10: all outputs SHALL be 0 at once; a following full Z=54 codeword SHALL match the model.
REQ-049 Back-to-back Z=54 then Z=27 codewords: Z=27 outputs SHALL have bits [80:27] = 0 and SHALL match the model.
